// File: rtl/ahb_addr_master.sv
// AHB-Lite address-phase master: pops start addresses from a FIFO
// and issues SINGLE/INCR bursts that never cross a 1KB boundary.
module ahb_addr_master (
    input  logic        clk,
    input  logic        reset,
    input  logic        fifo_empty,
    input  logic [31:0] fifo_data,
    output logic        fifo_rd_en,
    input  logic        cfg_write,
    input  logic [2:0]  cfg_size,
    input  logic [3:0]  cfg_len,
    input  logic        err_clr,
    output logic [31:0] haddr,
    output logic [1:0]  htrans,
    output logic        hwrite,
    output logic [2:0]  hsize,
    output logic [2:0]  hburst,
    input  logic        hready,
    input  logic        hresp,
    output logic        busy,
    output logic        err_flag
);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        LAST,
        ERR
    } state_t;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;

    state_t      state, state_nx;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  left_q, left_d;
    logic        wr_q, wr_d;
    logic [1:0]  sz_q, sz_d;
    logic        incr_q, incr_d;
    logic        first_q, first_d;
    logic        err_q, err_d;
    logic [1:0]  pop_sz;
    logic        fault;
    logic        err_set;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            addr_q  <= '0;
            left_q  <= '0;
            wr_q    <= 1'b0;
            sz_q    <= '0;
            incr_q  <= 1'b0;
            first_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nx;
            addr_q  <= addr_d;
            left_q  <= left_d;
            wr_q    <= wr_d;
            sz_q    <= sz_d;
            incr_q  <= incr_d;
            first_q <= first_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_nx   = state;
        addr_d     = addr_q;
        left_d     = left_q;
        wr_d       = wr_q;
        sz_d       = sz_q;
        incr_d     = incr_q;
        first_d    = first_q;
        err_d      = err_q;
        err_set    = 1'b0;
        fifo_rd_en = 1'b0;
        htrans     = T_IDLE;
        // oversized requests are clamped to a word
        pop_sz     = (cfg_size > 3'd2) ? 2'd2 : cfg_size[1:0];
        fault      = hresp && !hready;

        unique case (state)
            IDLE: begin
                fifo_rd_en = !fifo_empty && !reset;
                if (!fifo_empty) begin
                    state_nx = ADDR;
                    addr_d   = fifo_data
                             & ~((32'd1 << pop_sz) - 32'd1);
                    left_d   = cfg_len;
                    wr_d     = cfg_write;
                    sz_d     = pop_sz;
                    incr_d   = (cfg_len != 4'd0);
                    first_d  = 1'b1;
                end
            end
            ADDR: begin
                // restart with NONSEQ on every 1KB boundary
                if (first_q || addr_q[9:0] == 10'd0)
                    htrans = T_NONSEQ;
                else
                    htrans = T_SEQ;
                if (fault) begin
                    state_nx = ERR;
                    left_d   = '0;
                    err_set  = 1'b1;
                end else if (hready) begin
                    if (left_q != 4'd0) begin
                        addr_d  = addr_q + (32'd1 << sz_q);
                        left_d  = left_q - 4'd1;
                        first_d = 1'b0;
                    end else begin
                        state_nx = LAST;
                    end
                end
            end
            LAST: begin
                if (fault) begin
                    state_nx = ERR;
                    err_set  = 1'b1;
                end else if (hready) begin
                    state_nx = IDLE;
                end
            end
            ERR: begin
                if (hready)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase

        if (err_set)
            err_d = 1'b1;
        else if (err_clr)
            err_d = 1'b0;
    end

    assign haddr    = addr_q;
    assign hwrite   = wr_q;
    assign hsize    = {1'b0, sz_q};
    assign hburst   = {2'b00, incr_q};
    assign busy     = (state != IDLE);
    assign err_flag = err_q;

endmodule

// File: tb/tb_ahb_addr_master.sv
// Bench for ahb_addr_master: directed vector table, hand-written
// corner sequences, then random traffic against a beat-list model.
module tb_ahb_addr_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        fifo_empty;
    logic [31:0] fifo_data;
    logic        fifo_rd_en;
    logic        cfg_write;
    logic [2:0]  cfg_size;
    logic [3:0]  cfg_len;
    logic        err_clr;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic        hready;
    logic        hresp;
    logic        busy;
    logic        err_flag;

    always #5 clk = ~clk;

    ahb_addr_master dut (
        .clk       (clk),
        .reset     (reset),
        .fifo_empty(fifo_empty),
        .fifo_data (fifo_data),
        .fifo_rd_en(fifo_rd_en),
        .cfg_write (cfg_write),
        .cfg_size  (cfg_size),
        .cfg_len   (cfg_len),
        .err_clr   (err_clr),
        .haddr     (haddr),
        .htrans    (htrans),
        .hwrite    (hwrite),
        .hsize     (hsize),
        .hburst    (hburst),
        .hready    (hready),
        .hresp     (hresp),
        .busy      (busy),
        .err_flag  (err_flag)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic bus(input string nm,
                       input logic [31:0] a,
                       input logic [1:0] t);
        chk({nm, "_addr"}, haddr, a);
        chk({nm, "_trans"}, 32'(htrans), 32'(t));
    endtask

    typedef struct packed {
        logic        rst;
        logic        emp;
        logic [31:0] dat;
        logic        wr;
        logic [2:0]  sz;
        logic [3:0]  len;
        logic        rdy;
        logic        chkb;
        logic        e_rd;
        logic [31:0] e_addr;
        logic [1:0]  e_tr;
        logic        e_wr;
        logic [2:0]  e_sz;
        logic [2:0]  e_bu;
        logic        e_busy;
    } vec_t;

    vec_t tbl [19];

    typedef struct packed {
        logic [31:0] a;
        logic [1:0]  t;
        logic        w;
        logic [2:0]  s;
        logic [2:0]  b;
    } beat_t;

    beat_t q[$];
    bit    tail;
    bit    errph;
    bit    m_err;

    // expand one popped request into its full list of beats
    task automatic gen_beats();
        int unsigned sz;
        logic [31:0] step, base, a;
        beat_t bt;
        sz   = (cfg_size > 3'd2) ? 2 : int'(cfg_size);
        step = 32'd1 << sz;
        base = fifo_data & ~(step - 32'd1);
        for (int i = 0; i <= int'(cfg_len); i++) begin
            a    = base + 32'(i) * step;
            bt.a = a;
            bt.t = (i == 0 || a[9:0] == 10'd0) ? 2'b10 : 2'b11;
            bt.w = cfg_write;
            bt.s = 3'(sz);
            bt.b = (cfg_len == 4'd0) ? 3'b000 : 3'b001;
            q.push_back(bt);
        end
    endtask

    initial begin
        bit    ebusy, erd, fault;
        reset      = 1'b1;
        fifo_empty = 1'b1;
        fifo_data  = '0;
        cfg_write  = 1'b0;
        cfg_size   = '0;
        cfg_len    = '0;
        err_clr    = 1'b0;
        hready     = 1'b1;
        hresp      = 1'b0;

        tbl[0]  = '{0,1,32'h0,0,0,0,1,1, 0,32'h0,0,0,0,0,0};
        tbl[1]  = '{0,0,32'h1003,1,2,0,1,1, 1,32'h0,0,0,0,0,0};
        tbl[2]  = '{0,1,32'h0,0,0,5,1,1, 0,32'h1000,2,1,2,0,1};
        tbl[3]  = '{0,1,32'h0,0,0,0,1,0, 0,32'h0,0,0,0,0,1};
        tbl[4]  = '{0,1,32'h0,0,0,0,1,0, 0,32'h0,0,0,0,0,0};
        tbl[5]  = '{0,0,32'h3F8,0,2,3,1,0, 1,32'h0,0,0,0,0,0};
        tbl[6]  = '{0,1,32'h0,1,0,9,1,1, 0,32'h3F8,2,0,2,1,1};
        tbl[7]  = '{0,1,32'h0,1,0,9,1,1, 0,32'h3FC,3,0,2,1,1};
        tbl[8]  = '{0,1,32'h0,1,0,9,1,1, 0,32'h400,2,0,2,1,1};
        tbl[9]  = '{0,1,32'h0,1,0,9,1,1, 0,32'h404,3,0,2,1,1};
        tbl[10] = '{0,1,32'h0,0,0,0,0,0, 0,32'h0,0,0,0,0,1};
        tbl[11] = '{0,1,32'h0,0,0,0,1,0, 0,32'h0,0,0,0,0,1};
        tbl[12] = '{0,0,32'h2007,1,7,1,1,0, 1,32'h0,0,0,0,0,0};
        tbl[13] = '{0,1,32'h0,0,0,0,1,1, 0,32'h2004,2,1,2,1,1};
        tbl[14] = '{0,1,32'h0,0,0,0,1,1, 0,32'h2008,3,1,2,1,1};
        tbl[15] = '{0,0,32'h55,0,0,0,1,0, 0,32'h0,0,0,0,0,1};
        tbl[16] = '{0,0,32'h55,0,0,0,1,0, 1,32'h0,0,0,0,0,0};
        tbl[17] = '{1,0,32'h55,0,0,0,1,1, 0,32'h55,2,0,0,0,1};
        tbl[18] = '{0,1,32'h0,0,0,0,1,1, 0,32'h0,0,0,0,0,0};

        repeat (2) @(posedge clk);

        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            reset      = tbl[i].rst;
            fifo_empty = tbl[i].emp;
            fifo_data  = tbl[i].dat;
            cfg_write  = tbl[i].wr;
            cfg_size   = tbl[i].sz;
            cfg_len    = tbl[i].len;
            hready     = tbl[i].rdy;
            #1;
            chk($sformatf("t%0d_rd", i), 32'(fifo_rd_en),
                32'(tbl[i].e_rd));
            chk($sformatf("t%0d_trans", i), 32'(htrans),
                32'(tbl[i].e_tr));
            chk($sformatf("t%0d_busy", i), 32'(busy),
                32'(tbl[i].e_busy));
            chk($sformatf("t%0d_err", i), 32'(err_flag), 0);
            if (tbl[i].chkb) begin
                chk($sformatf("t%0d_addr", i), haddr,
                    tbl[i].e_addr);
                chk($sformatf("t%0d_wr", i), 32'(hwrite),
                    32'(tbl[i].e_wr));
                chk($sformatf("t%0d_size", i), 32'(hsize),
                    32'(tbl[i].e_sz));
                chk($sformatf("t%0d_burst", i), 32'(hburst),
                    32'(tbl[i].e_bu));
            end
        end

        // INCR4 with three wait states on the second beat
        @(negedge clk);
        reset = 0; fifo_empty = 0; fifo_data = 32'h100;
        cfg_write = 1; cfg_size = 2; cfg_len = 3;
        hready = 1; hresp = 0; err_clr = 0;
        #1 chk("ws_pop", 32'(fifo_rd_en), 1);
        @(negedge clk); fifo_empty = 1; cfg_len = 0;
        #1 bus("ws_b1", 32'h100, 2'b10);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); hready = (i == 3);
            #1 bus("ws_b2", 32'h104, 2'b11);
        end
        @(negedge clk); hready = 1;
        #1 bus("ws_b3", 32'h108, 2'b11);
        @(negedge clk);
        #1 bus("ws_b4", 32'h10C, 2'b11);
        chk("ws_burst", 32'(hburst), 1);
        chk("ws_wr", 32'(hwrite), 1);
        @(negedge clk);
        #1 chk("ws_last", 32'(htrans), 0);
        chk("ws_lbusy", 32'(busy), 1);
        @(negedge clk);
        #1 chk("ws_idle", 32'(busy), 0);

        // error response on beat 2 of an 8-beat burst
        @(negedge clk);
        fifo_empty = 0; fifo_data = 32'h200; cfg_len = 7;
        #1 chk("er_pop", 32'(fifo_rd_en), 1);
        @(negedge clk); fifo_empty = 1;
        #1 bus("er_b1", 32'h200, 2'b10);
        @(negedge clk); hready = 0; hresp = 1;
        #1 bus("er_b2", 32'h204, 2'b11);
        @(negedge clk); hready = 1; hresp = 1;
        #1 chk("er_trans", 32'(htrans), 0);
        chk("er_flag", 32'(err_flag), 1);
        chk("er_busy", 32'(busy), 1);
        @(negedge clk); hresp = 0;
        #1 chk("er_idle", 32'(busy), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 chk("er_nobeat", 32'(htrans), 0);
        end
        @(negedge clk); err_clr = 1;
        #1 chk("er_sticky", 32'(err_flag), 1);
        @(negedge clk); err_clr = 0;
        #1 chk("er_clr", 32'(err_flag), 0);

        // empty FIFO, then two queued words back to back
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); fifo_empty = 1;
            #1 chk("bb_erd", 32'(fifo_rd_en), 0);
            chk("bb_etr", 32'(htrans), 0);
        end
        @(negedge clk);
        fifo_empty = 0; fifo_data = 32'h40; cfg_len = 1;
        #1 chk("bb_pop1", 32'(fifo_rd_en), 1);
        @(negedge clk); fifo_data = 32'h80; cfg_len = 0;
        #1 bus("bb_a1", 32'h40, 2'b10);
        chk("bb_rd1", 32'(fifo_rd_en), 0);
        @(negedge clk);
        #1 bus("bb_a2", 32'h44, 2'b11);
        @(negedge clk);
        #1 chk("bb_gap1", 32'(htrans), 0);
        chk("bb_gaprd", 32'(fifo_rd_en), 0);
        @(negedge clk);
        #1 chk("bb_gap2", 32'(htrans), 0);
        chk("bb_pop2", 32'(fifo_rd_en), 1);
        @(negedge clk); fifo_empty = 1;
        #1 bus("bb_b1", 32'h80, 2'b10);
        chk("bb_single", 32'(hburst), 0);
        @(negedge clk);
        #1 chk("bb_last", 32'(htrans), 0);
        @(negedge clk);
        #1 chk("bb_idle", 32'(busy), 0);

        // reset during the third beat of an 8-beat burst
        @(negedge clk);
        fifo_empty = 0; fifo_data = 32'h300; cfg_len = 7;
        #1 chk("rs_pop", 32'(fifo_rd_en), 1);
        @(negedge clk);
        #1 bus("rs_b1", 32'h300, 2'b10);
        @(negedge clk);
        #1 bus("rs_b2", 32'h304, 2'b11);
        @(negedge clk); reset = 1;
        #1 bus("rs_b3", 32'h308, 2'b11);
        chk("rs_rd", 32'(fifo_rd_en), 0);
        @(negedge clk); reset = 0; fifo_empty = 1;
        #1 chk("rs_trans", 32'(htrans), 0);
        chk("rs_busy", 32'(busy), 0);
        chk("rs_addr", haddr, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 chk("rs_nobeat", 32'(htrans), 0);
        end

        // random traffic against the beat-list model
        q.delete();
        tail  = 0;
        errph = 0;
        m_err = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            reset      = ($urandom_range(0, 199) == 0);
            fifo_empty = ($urandom_range(0, 2) == 0);
            fifo_data  = $urandom;
            if ($urandom_range(0, 3) == 0)
                fifo_data[9:0] = 10'h3F0
                               + 10'($urandom_range(0, 15));
            cfg_write  = 1'($urandom);
            cfg_size   = 3'($urandom_range(0, 7));
            cfg_len    = 4'($urandom);
            hready     = ($urandom_range(0, 3) != 0);
            hresp      = ($urandom_range(0, 24) == 0);
            err_clr    = ($urandom_range(0, 19) == 0);
            #1;
            ebusy = (q.size() != 0) || tail || errph;
            erd   = !reset && !ebusy && !fifo_empty;
            chk("r_rd", 32'(fifo_rd_en), 32'(erd));
            chk("r_busy", 32'(busy), 32'(ebusy));
            chk("r_err", 32'(err_flag), 32'(m_err));
            if (q.size() != 0) begin
                bus("r_beat", q[0].a, q[0].t);
                chk("r_wr", 32'(hwrite), 32'(q[0].w));
                chk("r_size", 32'(hsize), 32'(q[0].s));
                chk("r_burst", 32'(hburst), 32'(q[0].b));
            end else begin
                chk("r_idle", 32'(htrans), 0);
            end

            if (reset) begin
                q.delete();
                tail  = 0;
                errph = 0;
                m_err = 0;
            end else begin
                fault = ((q.size() != 0) || tail)
                      && hresp && !hready;
                if (fault) begin
                    q.delete();
                    tail  = 0;
                    errph = 1;
                    m_err = 1;
                end else begin
                    if (err_clr) m_err = 0;
                    if (q.size() != 0) begin
                        if (hready) begin
                            void'(q.pop_front());
                            if (q.size() == 0) tail = 1;
                        end
                    end else if (tail) begin
                        if (hready) tail = 0;
                    end else if (errph) begin
                        if (hready) errph = 0;
                    end else if (erd) begin
                        gen_beats();
                    end
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
